serial_frame_receiver: RTL and testbench

Upstream front end of the neural network. Receives a pixel frame on the Arduino two-wire serial link (serialClock, serialData) and synchronizes it into the system clock domain. Assembles the bits into numInputs words of dataWidth bits, held in a flat parallel frame register. Tells the NN control FSM, through a valid/ack handshake, when a complete frame is ready. Replaces the direct serial-clocked input shift register: all storage is clocked by clk.

---
 rtl/nn_pkg.sv | 20 ++
 rtl/bit_synchronizer.sv | 32 +++
 rtl/serial_frame_receiver.sv | 191 +++++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : nn_pkg                                                 |
// | Brief   : Constants and shared receiver state type for the NN    |
// |           datapath (frame size, pixel width, rx FSM states).     |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package nn_pkg;

  localparam int NUM_INPUTS = 784;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/bit_synchronizer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : bit_synchronizer                                       |
// | Brief   : Multi-flop synchronizer for one asynchronous bit, with |
// |           a selectable reset value.                              |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module bit_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the async input through the synchronizer chain
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= {STAGES{RESET_VALUE}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/serial_frame_receiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : serial_frame_receiver                                  |
// | Brief   : Two-wire serial pixel-frame receiver. Synchronizes the |
// |           link into clk, assembles MSB-first words into a flat   |
// |           frame register and hands it over via valid/ack.        |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module serial_frame_receiver #(
  parameter int NUM_INPUTS     = nn_pkg::NUM_INPUTS,
  parameter int DATA_WIDTH     = nn_pkg::DATA_WIDTH,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                serialClock,
  input  logic                                serialData,
  input  logic                                frameAck,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0]    dataOut,
  output logic                                frameValid,
  output logic                                busy,
  output logic                                overrun,
  output logic                                timeoutErr,
  output logic [$clog2(NUM_INPUTS+1)-1:0]     pixelCount
);

  import nn_pkg::*;

  localparam int c_PIX_W  = $clog2(NUM_INPUTS + 1);
  localparam int c_BIT_W  = $clog2(DATA_WIDTH);
  localparam int c_IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(DATA_WIDTH - 1);
  localparam logic [c_PIX_W-1:0]  c_LAST_PIX  = c_PIX_W'(NUM_INPUTS - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(TIMEOUT_CYCLES - 1);

  logic                  w_sclk;
  logic                  w_sdata;
  logic                  r_sclk_prev;
  logic                  r_edge;
  logic                  r_bit;
  rx_state_t             r_state;
  rx_state_t             w_next_state;
  logic [DATA_WIDTH-2:0] r_shift;
  logic [DATA_WIDTH-1:0] w_word;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [c_PIX_W-1:0]    r_pix_cnt;
  logic [c_IDLE_W-1:0]   r_idle_cnt;
  logic                  r_overrun;
  logic                  r_timeout;
  logic                  w_accept;
  logic                  w_word_done;
  logic                  w_store;
  logic                  w_timeout;

  // Both link lines idle high, so their synchronizers reset to 1
  bit_synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_sync_clk (
    .clk    (clk),
    .resetn (resetn),
    .d      (serialClock),
    .q      (w_sclk)
  );

  bit_synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_sync_data (
    .clk    (clk),
    .resetn (resetn),
    .d      (serialData),
    .q      (w_sdata)
  );

  // Register the rising-edge strobe together with the data bit seen at that edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sclk_prev <= 1'b1;
      r_edge      <= 1'b0;
      r_bit       <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk;
      r_edge      <= w_sclk & ~r_sclk_prev;
      r_bit       <= w_sdata;
    end
  end

  assign w_word      = {r_shift, r_bit};
  assign w_accept    = r_edge && (r_state != HOLD);
  assign w_word_done = (r_bit_cnt == c_LAST_BIT);
  assign w_store     = w_accept && w_word_done;
  assign w_timeout   = (r_state == RECV) && !r_edge && (r_idle_cnt == c_IDLE_LAST);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: start on first edge, hold after the last word, abort on idle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (r_edge) begin
          w_next_state = RECV;
        end
      end
      RECV: begin
        if (w_store && (r_pix_cnt == c_LAST_PIX)) begin
          w_next_state = HOLD;
        end else if (w_timeout) begin
          w_next_state = IDLE;
        end
      end
      HOLD: begin
        if (frameAck) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Bit/word counters, shift register, idle timer and status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_pix_cnt  <= '0;
      r_idle_cnt <= '0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_timeout;
      if ((r_state == HOLD) && r_edge) begin
        r_overrun <= 1'b1;
      end
      if ((r_state == RECV) && !r_edge && !w_timeout) begin
        r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
      end else begin
        r_idle_cnt <= '0;
      end
      if (w_accept) begin
        r_shift <= w_word[DATA_WIDTH-2:0];
        if (w_word_done) begin
          r_bit_cnt <= '0;
          r_pix_cnt <= r_pix_cnt + c_PIX_W'(1);
        end else begin
          r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
        end
      end else if (w_timeout) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
      end else if ((r_state == HOLD) && frameAck) begin
        r_pix_cnt <= '0;
      end
    end
  end

  // One register per pixel slot; only the slot currently being filled loads
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_slot;

    // Capture the completed word when this slot is next in line
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_slot <= '0;
      end else if (w_store && (r_pix_cnt == c_PIX_W'(k))) begin
        r_slot <= w_word;
      end
    end

    assign dataOut[k*DATA_WIDTH +: DATA_WIDTH] = r_slot;
  end

  assign frameValid = (r_state == HOLD);
  assign busy       = (r_state == RECV);
  assign overrun    = r_overrun;
  assign timeoutErr = r_timeout;
  assign pixelCount = r_pix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_receiver.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_serial_frame_receiver                               |
// | Brief   : Directed self-checking bench for serial_frame_receiver |
// |           using a reduced frame size.                            |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_serial_frame_receiver;

  localparam int N     = 8;
  localparam int DW    = 16;
  localparam int S     = 2;
  localparam int T     = 100;
  localparam int PHASE = 8;
  localparam int PW    = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              serialClock = 1'b1;
  logic              serialData = 1'b1;
  logic              frameAck = 1'b0;
  logic [N*DW-1:0]   dataOut;
  logic              frameValid;
  logic              busy;
  logic              overrun;
  logic              timeoutErr;
  logic [PW-1:0]     pixelCount;

  int                tests = 0;
  int                fails = 0;
  int                fv_lat = 0;
  int                te_lat;
  int                te_pulses;
  logic [N*DW-1:0]   saved;

  serial_frame_receiver #(
    .NUM_INPUTS     (N),
    .DATA_WIDTH     (DW),
    .SYNC_STAGES    (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .serialClock (serialClock),
    .serialData  (serialData),
    .frameAck    (frameAck),
    .dataOut     (dataOut),
    .frameValid  (frameValid),
    .busy        (busy),
    .overrun     (overrun),
    .timeoutErr  (timeoutErr),
    .pixelCount  (pixelCount)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: observed no finish, expected finish before 600us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected pixel value for each test pattern
  function automatic logic [DW-1:0] pix(input int pat, input int k);
    case (pat)
      1:       return DW'(k * 16);
      2:       return DW'(16'hFFFF - k);
      3:       return 16'h0100;
      4:       return DW'(k * 16 + 16'h0A05);
      default: return DW'(16'hA5A5 ^ k);
    endcase
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    serialClock = 1'b0;
    serialData  = b;
    repeat (PHASE - 1) @(negedge clk);
    @(negedge clk);
    serialClock = 1'b1;
    fv_lat = 0;
    for (int i = 1; i <= PHASE; i++) begin
      @(posedge clk);
      #1;
      if (frameValid && fv_lat == 0) fv_lat = i;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_frame(input int pat, input string tag);
    check({tag, "_latency"}, N*DW'(fv_lat), N*DW'(S + 2));
    check({tag, "_valid"}, N*DW'(frameValid), N*DW'(1));
    check({tag, "_count"}, N*DW'(pixelCount), N*DW'(N));
    check({tag, "_busy"}, N*DW'(busy), '0);
    for (int k = 0; k < N; k++) begin
      check({tag, "_pix"}, N*DW'(dataOut[k*DW +: DW]), N*DW'(pix(pat, k)));
    end
  endtask

  task automatic pulse_ack;
    @(negedge clk);
    frameAck = 1'b1;
    @(negedge clk);
    frameAck = 1'b0;
  endtask

  initial begin
    // 1: reset with the link clock held high
    repeat (3) @(negedge clk);
    check("rst_data", dataOut, '0);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_valid", N*DW'(frameValid), '0);
    check("rst_busy", N*DW'(busy), '0);
    check("rst_count", N*DW'(pixelCount), '0);
    check("rst_overrun", N*DW'(overrun), '0);
    check("rst_timeout", N*DW'(timeoutErr), '0);
    check("rst_data2", dataOut, '0);

    // 2: first frame, pixel k = k*16
    for (int k = 0; k < N; k++) send_word(pix(1, k));
    check_frame(1, "f1");
    check("f1_overrun", N*DW'(overrun), '0);

    // 3: ack then second frame, pixel k = 0xFFFF-k
    pulse_ack();
    check("ack_valid", N*DW'(frameValid), '0);
    check("ack_count", N*DW'(pixelCount), '0);
    check("ack_keep", N*DW'(dataOut[(N-1)*DW +: DW]), N*DW'(pix(1, N - 1)));
    for (int k = 0; k < N; k++) send_word(pix(2, k));
    check_frame(2, "f2");

    // 4: extra edges while holding a frame
    saved = dataOut;
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    check("ovr_flag", N*DW'(overrun), N*DW'(1));
    check("ovr_frozen", dataOut, saved);
    check("ovr_valid", N*DW'(frameValid), N*DW'(1));
    pulse_ack();
    check("ovr_ack_valid", N*DW'(frameValid), '0);
    send_word(pix(3, 0));
    send_word(pix(3, 1));
    pulse_ack();
    check("midack_count", N*DW'(pixelCount), N*DW'(2));
    check("midack_busy", N*DW'(busy), N*DW'(1));
    for (int k = 2; k < N; k++) send_word(pix(3, k));
    check_frame(3, "f3");
    check("f3_overrun_sticky", N*DW'(overrun), N*DW'(1));
    pulse_ack();

    // 5: 20 bits then silence -> timeout abort
    send_word(16'h1234);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    serialClock = 1'b0;
    serialData  = 1'b0;
    repeat (PHASE - 1) @(negedge clk);
    @(negedge clk);
    serialClock = 1'b1;
    te_lat = 0;
    te_pulses = 0;
    for (int i = 1; i <= 150; i++) begin
      @(posedge clk);
      #1;
      if (i == PHASE) serialClock = 1'b0;
      if (i == 10) check("to_busy_mid", N*DW'(busy), N*DW'(1));
      if (timeoutErr) begin
        te_pulses++;
        if (te_lat == 0) te_lat = i;
      end
    end
    check("to_latency", N*DW'(te_lat), N*DW'(S + 2 + T));
    check("to_pulses", N*DW'(te_pulses), N*DW'(1));
    check("to_count", N*DW'(pixelCount), '0);
    check("to_busy", N*DW'(busy), '0);
    for (int k = 0; k < N; k++) send_word(pix(4, k));
    check_frame(4, "f4");
    pulse_ack();

    // 6: asynchronous reset mid-frame
    for (int k = 0; k < 3; k++) send_word(pix(5, k));
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_data", dataOut, '0);
    check("arst_count", N*DW'(pixelCount), '0);
    check("arst_busy", N*DW'(busy), '0);
    check("arst_overrun", N*DW'(overrun), '0);
    check("arst_valid", N*DW'(frameValid), '0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < N; k++) send_word(pix(5, k));
    check_frame(5, "f5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
